// File: rtl/esc_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : esc_frame_scheduler
// Description : Owns all SPEED/wrt traffic to the four ESC_interface blocks.
//               Captures requested motor speeds and runs an arm / spin-up /
//               armed state machine. Each speed is slew-limited per frame.
//               One wrt pulse per frame goes to all four ESCs, and motors are
//               killed at once on disarm.
// Ports       : clk, rst_n (sync, active-low)
//               arm      - level, 1 = motors enabled
//               spd_vld  - strobe, capture the four *_spd requests
//               *_spd    - requested speeds (11 bit)
//               *_out    - SPEED to each ESC (11 bit)
//               wrt      - one-cycle update pulse; *_out valid in that cycle
//               armed    - state machine is in ARMED
// Revision    : 1.0 - initial release
// ============================================================================
module esc_frame_scheduler #(
    parameter int          FRAME_CLKS = 262144,
    parameter logic [10:0] MAX_STEP   = 11'd64,
    parameter int          ARM_FRAMES = 8,
    parameter logic [10:0] IDLE_SPD   = 11'd50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        spd_vld,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic [10:0] frnt_out,
    output logic [10:0] bck_out,
    output logic [10:0] lft_out,
    output logic [10:0] rght_out,
    output logic        wrt,
    output logic        armed
);

    localparam int c_CW = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
    localparam int c_SW = $clog2(ARM_FRAMES + 1);

    localparam logic [c_CW-1:0] c_TICK_CNT  = c_CW'(FRAME_CLKS - 1);
    localparam logic [c_SW-1:0] c_SPIN_LAST = c_SW'(ARM_FRAMES - 1);

    localparam logic [1:0] c_ST_DISARMED = 2'd0;
    localparam logic [1:0] c_ST_SPINUP   = 2'd1;
    localparam logic [1:0] c_ST_ARMED    = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_SW-1:0] r_spin_cnt;
    logic [c_SW-1:0] w_spin_nxt;
    logic [c_CW-1:0] r_frm_cnt;
    logic [10:0]     r_frnt_req, r_bck_req, r_lft_req, r_rght_req;
    logic [10:0]     r_frnt_out, r_bck_out, r_lft_out, r_rght_out;
    logic            r_wrt;
    logic            w_tick;
    logic            w_disarm;

    assign w_tick   = (r_frm_cnt == c_TICK_CNT);
    // Dropping arm only matters when motors could be turning; in DISARMED
    // it must not generate an extra wrt.
    assign w_disarm = !arm && (r_state != c_ST_DISARMED);

    // One slew step toward max(req, IDLE_SPD). All math is 12 bit so the
    // +/- MAX_STEP comparisons cannot wrap at either end of the range.
    function automatic logic [10:0] f_slew(input logic [10:0] cur,
                                           input logic [10:0] req);
        logic [11:0] v_tgt;
        logic [11:0] v_cur;
        logic [11:0] v_step;
        logic [11:0] v_res;
        v_tgt  = (req < IDLE_SPD) ? {1'b0, IDLE_SPD} : {1'b0, req};
        v_cur  = {1'b0, cur};
        v_step = {1'b0, MAX_STEP};
        if (v_tgt > v_cur + v_step)
            v_res = v_cur + v_step;
        else if (v_tgt + v_step < v_cur)
            v_res = v_cur - v_step;
        else
            v_res = v_tgt;
        return v_res[10:0];
    endfunction

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_DISARMED;
            r_spin_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_spin_cnt <= w_spin_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_spin_nxt  = r_spin_cnt;
        case (r_state)
            c_ST_DISARMED: begin
                if (arm) begin
                    w_state_nxt = c_ST_SPINUP;
                    w_spin_nxt  = '0;
                end
            end
            c_ST_SPINUP: begin
                if (!arm) begin
                    w_state_nxt = c_ST_DISARMED;
                end else if (w_tick) begin
                    w_spin_nxt = r_spin_cnt + 1'b1;
                    if (r_spin_cnt == c_SPIN_LAST)
                        w_state_nxt = c_ST_ARMED;
                end
            end
            c_ST_ARMED: begin
                if (!arm)
                    w_state_nxt = c_ST_DISARMED;
            end
            default: w_state_nxt = c_ST_DISARMED;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame timing, request capture and output update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frm_cnt  <= '0;
            r_wrt      <= 1'b0;
            r_frnt_req <= '0;
            r_bck_req  <= '0;
            r_lft_req  <= '0;
            r_rght_req <= '0;
            r_frnt_out <= '0;
            r_bck_out  <= '0;
            r_lft_out  <= '0;
            r_rght_out <= '0;
        end else begin
            // A disarm restarts the frame so the next wrt is a full frame out.
            if (w_disarm || w_tick)
                r_frm_cnt <= '0;
            else
                r_frm_cnt <= r_frm_cnt + 1'b1;

            r_wrt <= w_disarm || w_tick;

            // Ticks read the pre-edge request, so a strobe landing on a tick
            // is only seen by the following frame.
            if (spd_vld) begin
                r_frnt_req <= frnt_spd;
                r_bck_req  <= bck_spd;
                r_lft_req  <= lft_spd;
                r_rght_req <= rght_spd;
            end

            if (w_disarm) begin
                r_frnt_out <= '0;
                r_bck_out  <= '0;
                r_lft_out  <= '0;
                r_rght_out <= '0;
            end else if (w_tick) begin
                case (r_state)
                    c_ST_SPINUP: begin
                        r_frnt_out <= IDLE_SPD;
                        r_bck_out  <= IDLE_SPD;
                        r_lft_out  <= IDLE_SPD;
                        r_rght_out <= IDLE_SPD;
                    end
                    c_ST_ARMED: begin
                        r_frnt_out <= f_slew(r_frnt_out, r_frnt_req);
                        r_bck_out  <= f_slew(r_bck_out,  r_bck_req);
                        r_lft_out  <= f_slew(r_lft_out,  r_lft_req);
                        r_rght_out <= f_slew(r_rght_out, r_rght_req);
                    end
                    default: begin
                        r_frnt_out <= '0;
                        r_bck_out  <= '0;
                        r_lft_out  <= '0;
                        r_rght_out <= '0;
                    end
                endcase
            end
        end
    end

    assign frnt_out = r_frnt_out;
    assign bck_out  = r_bck_out;
    assign lft_out  = r_lft_out;
    assign rght_out = r_rght_out;
    assign wrt      = r_wrt;
    assign armed    = (r_state == c_ST_ARMED);

endmodule
`default_nettype wire

// File: tb/tb_esc_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_esc_frame_scheduler
// Description : Directed self-checking bench for esc_frame_scheduler with
//               FRAME_CLKS=100, MAX_STEP=64, ARM_FRAMES=4, IDLE_SPD=50.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_esc_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic        spd_vld;
    logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
    logic [10:0] frnt_out, bck_out, lft_out, rght_out;
    logic        wrt;
    logic        armed;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        upd;
        logic [10:0] f, b, l, r;
        logic [10:0] ef, eb, el, er;
        logic        ea;
    } vec_t;

    vec_t tbl[13];

    esc_frame_scheduler #(
        .FRAME_CLKS (100),
        .MAX_STEP   (11'd64),
        .ARM_FRAMES (4),
        .IDLE_SPD   (11'd50)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .spd_vld  (spd_vld),
        .frnt_spd (frnt_spd),
        .bck_spd  (bck_spd),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .frnt_out (frnt_out),
        .bck_out  (bck_out),
        .lft_out  (lft_out),
        .rght_out (rght_out),
        .wrt      (wrt),
        .armed    (armed)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input int ef, input int eb,
                            input int el, input int er);
        chk({name, "_frnt"}, int'(frnt_out), ef);
        chk({name, "_bck"},  int'(bck_out),  eb);
        chk({name, "_lft"},  int'(lft_out),  el);
        chk({name, "_rght"}, int'(rght_out), er);
    endtask

    // Steps until wrt is seen; n = number of cycles taken.
    task automatic wait_wrt(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!wrt && n < 250);
        if (!wrt)
            chk("wrt_timeout", 0, 1);
    endtask

    task automatic set_req(input logic [10:0] f, input logic [10:0] b,
                           input logic [10:0] l, input logic [10:0] r);
        frnt_spd = f; bck_spd = b; lft_spd = l; rght_spd = r;
        spd_vld  = 1'b1;
        step();
        spd_vld  = 1'b0;
    endtask

    initial begin
        int n;
        int e;

        // Spin-up frames, floor at idle, then frnt slew 50->300->50.
        tbl[0]  = '{1'b0, 11'd0,   11'd0, 11'd0, 11'd0, 11'd50,  11'd50, 11'd50, 11'd50, 1'b0};
        tbl[1]  = '{1'b0, 11'd0,   11'd0, 11'd0, 11'd0, 11'd50,  11'd50, 11'd50, 11'd50, 1'b0};
        tbl[2]  = '{1'b0, 11'd0,   11'd0, 11'd0, 11'd0, 11'd50,  11'd50, 11'd50, 11'd50, 1'b0};
        tbl[3]  = '{1'b0, 11'd0,   11'd0, 11'd0, 11'd0, 11'd50,  11'd50, 11'd50, 11'd50, 1'b1};
        tbl[4]  = '{1'b0, 11'd0,   11'd0, 11'd0, 11'd0, 11'd50,  11'd50, 11'd50, 11'd50, 1'b1};
        tbl[5]  = '{1'b1, 11'd300, 11'd0, 11'd0, 11'd0, 11'd114, 11'd50, 11'd50, 11'd50, 1'b1};
        tbl[6]  = '{1'b0, 11'd0,   11'd0, 11'd0, 11'd0, 11'd178, 11'd50, 11'd50, 11'd50, 1'b1};
        tbl[7]  = '{1'b0, 11'd0,   11'd0, 11'd0, 11'd0, 11'd242, 11'd50, 11'd50, 11'd50, 1'b1};
        tbl[8]  = '{1'b0, 11'd0,   11'd0, 11'd0, 11'd0, 11'd300, 11'd50, 11'd50, 11'd50, 1'b1};
        tbl[9]  = '{1'b1, 11'd0,   11'd0, 11'd0, 11'd0, 11'd236, 11'd50, 11'd50, 11'd50, 1'b1};
        tbl[10] = '{1'b0, 11'd0,   11'd0, 11'd0, 11'd0, 11'd172, 11'd50, 11'd50, 11'd50, 1'b1};
        tbl[11] = '{1'b0, 11'd0,   11'd0, 11'd0, 11'd0, 11'd108, 11'd50, 11'd50, 11'd50, 1'b1};
        tbl[12] = '{1'b0, 11'd0,   11'd0, 11'd0, 11'd0, 11'd50,  11'd50, 11'd50, 11'd50, 1'b1};

        rst_n = 1'b0; arm = 1'b0; spd_vld = 1'b0;
        frnt_spd = '0; bck_spd = '0; lft_spd = '0; rght_spd = '0;

        // Reset state
        repeat (3) step();
        chk_outs("rst", 0, 0, 0, 0);
        chk("rst_wrt", int'(wrt), 0);
        chk("rst_armed", int'(armed), 0);

        // Disarmed frames: wrt at cycles 100 and 200 after release
        rst_n = 1'b1;
        wait_wrt(n);
        chk("first_wrt_cycle", n, 100);
        chk_outs("dis_wrt1", 0, 0, 0, 0);
        step();
        chk("wrt_one_cycle", int'(wrt), 0);
        wait_wrt(n);
        chk("second_wrt_cycle", n + 1, 100);
        chk_outs("dis_wrt2", 0, 0, 0, 0);
        chk("dis_armed", int'(armed), 0);

        // Arm, spin up, then slew via the vector table
        arm = 1'b1;
        foreach (tbl[i]) begin
            if (tbl[i].upd)
                set_req(tbl[i].f, tbl[i].b, tbl[i].l, tbl[i].r);
            wait_wrt(n);
            chk_outs($sformatf("vec%0d", i), int'(tbl[i].ef), int'(tbl[i].eb),
                     int'(tbl[i].el), int'(tbl[i].er));
            chk($sformatf("vec%0d_armed", i), int'(armed), int'(tbl[i].ea));
        end

        // spd_vld coincident with a tick: old request used on that tick
        repeat (99) step();
        frnt_spd = 11'd500;
        spd_vld  = 1'b1;
        step();
        spd_vld  = 1'b0;
        chk("coinc_wrt", int'(wrt), 1);
        chk("coinc_old_req", int'(frnt_out), 50);
        wait_wrt(n);
        chk("coinc_period", n, 100);
        chk("coinc_new_req", int'(frnt_out), 114);

        // Back to idle, then full-scale request
        set_req(11'd0, 11'd0, 11'd0, 11'd0);
        wait_wrt(n);
        chk("back_to_idle", int'(frnt_out), 50);
        set_req(11'd2047, 11'd2047, 11'd2047, 11'd2047);
        for (int k = 1; k <= 32; k++) begin
            wait_wrt(n);
            e = 50 + 64 * k;
            if (e > 2047) e = 2047;
            chk($sformatf("max_frnt_t%0d", k), int'(frnt_out), e);
            chk($sformatf("max_rght_t%0d", k), int'(rght_out), e);
        end
        wait_wrt(n);
        chk_outs("max_hold", 2047, 2047, 2047, 2047);

        // Disarm mid-frame at frm_cnt=37
        repeat (37) step();
        arm = 1'b0;
        step();
        chk_outs("disarm", 0, 0, 0, 0);
        chk("disarm_wrt", int'(wrt), 1);
        chk("disarm_armed", int'(armed), 0);
        step();
        chk("disarm_wrt_drop", int'(wrt), 0);
        wait_wrt(n);
        chk("disarm_next_wrt", n + 1, 100);
        chk_outs("disarm_next", 0, 0, 0, 0);

        // arm raised on a tick cycle: that tick still uses DISARMED rules
        repeat (99) step();
        arm = 1'b1;
        step();
        chk("arm_on_tick_wrt", int'(wrt), 1);
        chk("arm_on_tick_out", int'(frnt_out), 0);
        wait_wrt(n);
        chk("spinup_first", int'(frnt_out), 50);
        chk("spinup_armed", int'(armed), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
